// File: rtl/infer_sequencer.sv
// Periodic inference scheduler: samples a GRID x GRID pixel lattice from the frame buffer,
// runs the CNN, and forwards the one-hot verdict to the inter-board messenger.
module infer_sequencer #(
  parameter int GRID        = 25,
  parameter int ROW_STRIDE  = 9,
  parameter int COL_STRIDE  = 12,
  parameter int LINE_W      = 320,
  parameter int PERIOD      = 100_000_000,
  parameter int RD_LAT      = 2,
  parameter int CNN_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [16:0] fb_raddr,
  input  logic [11:0] fb_rdata,
  output logic        smp_we,
  output logic [9:0]  smp_idx,
  output logic [11:0] smp_data,
  output logic        cnn_start,
  input  logic        cnn_finish,
  input  logic [3:0]  cnn_class,
  output logic [7:0]  msg_in,
  output logic        msg_request,
  input  logic        msg_done,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout,
  output logic        err_class,
  output logic [7:0]  frame_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SAMPLE   = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_CNN = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_WAIT_ACK = 3'd6;

  localparam int TICK_W = $clog2(PERIOD + 1);
  localparam int TO_W   = $clog2(CNN_TIMEOUT + 1);
  localparam int COL_W  = $clog2(GRID + 1);
  localparam int NSMP   = GRID * GRID;
  localparam logic [16:0] ROW_STEP = 17'(ROW_STRIDE * LINE_W);
  localparam logic [16:0] COL_STEP = 17'(COL_STRIDE);

  logic [2:0]        state;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [TO_W-1:0]   to_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [9:0]        smp_cnt;
  logic [16:0]       row_base;
  logic [16:0]       col_off;
  logic [16:0]       col_off_nxt;
  logic              issue;
  logic              drain_busy;

  logic [RD_LAT-1:0] vld_p;
  logic [9:0]        idx_p [RD_LAT];

  assign tick = enable && (tick_cnt == TICK_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign issue       = (state == S_SAMPLE);
  assign col_off_nxt = col_off + COL_STEP;

  // Return pipeline: valid/index travel alongside the frame buffer read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= smp_cnt;
    for (int i = 1; i < RD_LAT; i++) idx_p[i] <= idx_p[i-1];
  end

  // Drain is complete once only the final stage (if anything) still holds a sample
  always_comb begin
    drain_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) drain_busy = drain_busy | vld_p[i];
  end

  assign smp_we   = vld_p[RD_LAT-1];
  assign smp_idx  = vld_p[RD_LAT-1] ? idx_p[RD_LAT-1] : 10'd0;
  assign smp_data = vld_p[RD_LAT-1] ? fb_rdata : 12'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      col_cnt     <= '0;
      smp_cnt     <= '0;
      row_base    <= '0;
      col_off     <= '0;
      fb_raddr    <= '0;
      to_cnt      <= '0;
      msg_in      <= '0;
      frame_cnt   <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      err_class   <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) err_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state    <= S_SAMPLE;
            col_cnt  <= '0;
            smp_cnt  <= '0;
            row_base <= '0;
            col_off  <= '0;
            fb_raddr <= '0;
          end
        end
        S_SAMPLE: begin
          smp_cnt <= smp_cnt + 10'd1;
          if (smp_cnt == 10'(NSMP - 1)) begin
            state <= S_DRAIN;
          end else if (col_cnt == COL_W'(GRID - 1)) begin
            col_cnt  <= '0;
            col_off  <= '0;
            row_base <= row_base + ROW_STEP;
            fb_raddr <= row_base + ROW_STEP;
          end else begin
            col_cnt  <= col_cnt + 1'b1;
            col_off  <= col_off_nxt;
            fb_raddr <= row_base + col_off_nxt;
          end
        end
        S_DRAIN: begin
          if (!drain_busy) state <= S_START;
        end
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT_CNN;
        end
        S_WAIT_CNN: begin
          if (cnn_finish) begin
            if (cnn_class[3]) begin
              err_class <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
              state     <= S_IDLE;
            end else begin
              msg_in <= 8'd1 << cnn_class[2:0];
              state  <= S_SEND;
            end
          end else if (to_cnt == TO_W'(CNN_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SEND: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (msg_done) begin
            frame_cnt <= frame_cnt + 8'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign cnn_start   = (state == S_START);
  assign msg_request = (state == S_SEND);

endmodule

// File: tb/tb_infer_sequencer.sv
// Directed bench for infer_sequencer: instance A (PERIOD=1000, RD_LAT=2) covers sampling, happy path
// and bad class; instance B (PERIOD=700, RD_LAT=3, CNN_TIMEOUT=50) covers timeout, overrun and reset.
module tb_infer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic enable_a, enable_b;

  logic [16:0] fb_raddr_a, fb_raddr_b;
  logic [11:0] fb_rdata_a, fb_rdata_b;
  logic        smp_we_a, smp_we_b;
  logic [9:0]  smp_idx_a, smp_idx_b;
  logic [11:0] smp_data_a, smp_data_b;
  logic        cnn_start_a, cnn_start_b;
  logic        cnn_finish_a, cnn_finish_b;
  logic [3:0]  cnn_class_a, cnn_class_b;
  logic [7:0]  msg_in_a, msg_in_b;
  logic        msg_request_a, msg_request_b;
  logic        msg_done_a, msg_done_b;
  logic        busy_a, busy_b;
  logic        err_overrun_a, err_overrun_b;
  logic        err_timeout_a, err_timeout_b;
  logic        err_class_a, err_class_b;
  logic [7:0]  frame_cnt_a, frame_cnt_b;

  infer_sequencer #(.PERIOD(1000), .RD_LAT(2), .CNN_TIMEOUT(300)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a),
    .fb_raddr(fb_raddr_a), .fb_rdata(fb_rdata_a),
    .smp_we(smp_we_a), .smp_idx(smp_idx_a), .smp_data(smp_data_a),
    .cnn_start(cnn_start_a), .cnn_finish(cnn_finish_a), .cnn_class(cnn_class_a),
    .msg_in(msg_in_a), .msg_request(msg_request_a), .msg_done(msg_done_a),
    .busy(busy_a), .err_overrun(err_overrun_a), .err_timeout(err_timeout_a),
    .err_class(err_class_a), .frame_cnt(frame_cnt_a)
  );

  infer_sequencer #(.PERIOD(700), .RD_LAT(3), .CNN_TIMEOUT(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b),
    .fb_raddr(fb_raddr_b), .fb_rdata(fb_rdata_b),
    .smp_we(smp_we_b), .smp_idx(smp_idx_b), .smp_data(smp_data_b),
    .cnn_start(cnn_start_b), .cnn_finish(cnn_finish_b), .cnn_class(cnn_class_b),
    .msg_in(msg_in_b), .msg_request(msg_request_b), .msg_done(msg_done_b),
    .busy(busy_b), .err_overrun(err_overrun_b), .err_timeout(err_timeout_b),
    .err_class(err_class_b), .frame_cnt(frame_cnt_b)
  );

  // Frame buffer models: data = address low 12 bits, returned RD_LAT cycles later
  logic [16:0] fa_d [2];
  logic [16:0] fbd_d [3];
  always @(posedge clk) begin
    fa_d[0]  <= fb_raddr_a;
    fa_d[1]  <= fa_d[0];
    fbd_d[0] <= fb_raddr_b;
    fbd_d[1] <= fbd_d[0];
    fbd_d[2] <= fbd_d[1];
  end
  assign fb_rdata_a = fa_d[1][11:0];
  assign fb_rdata_b = fbd_d[2][11:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nwe_a = 0, nst_a = 0, nrq_a = 0;
  int nwe_b = 0, nst_b = 0, nrq_b = 0;
  always @(negedge clk) begin
    if (smp_we_a)      nwe_a <= nwe_a + 1;
    if (cnn_start_a)   nst_a <= nst_a + 1;
    if (msg_request_a) nrq_a <= nrq_a + 1;
    if (smp_we_b)      nwe_b <= nwe_b + 1;
    if (cnn_start_b)   nst_b <= nst_b + 1;
    if (msg_request_b) nrq_b <= nrq_b + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      2:       return cnn_start_a;
      default: return cnn_start_b;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input logic val, input int lim,
                          output int at);
    for (int i = 0; i < lim && sig_of(which) !== val; i++) step();
    at = cyc;
    chk(tag, 64'(sig_of(which)), 64'(val));
  endtask

  function automatic int addr_of(input int k);
    return (k / 25) * 9 * 320 + (k % 25) * 12;
  endfunction

  initial begin
    int ea, eb, s, c, at, wr, lat, rel, we0, st0;
    rst_n = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0;
    cnn_finish_a = 1'b0; cnn_finish_b = 1'b0;
    cnn_class_a = 4'd0; cnn_class_b = 4'd0;
    msg_done_a = 1'b0; msg_done_b = 1'b0;
    repeat (3) step();

    chk("reset_outputs_a", {fb_raddr_a, smp_we_a, smp_idx_a, smp_data_a, cnn_start_a, msg_in_a,
        msg_request_a, busy_a, err_overrun_a, err_timeout_a, err_class_a, frame_cnt_a}, 64'd0);
    chk("reset_outputs_b", {fb_raddr_b, smp_we_b, smp_idx_b, smp_data_b, cnn_start_b, msg_in_b,
        msg_request_b, busy_b, err_overrun_b, err_timeout_b, err_class_b, frame_cnt_b}, 64'd0);
    rst_n = 1'b1;
    step();

    // ---- Instance A: sampling sequence ----
    enable_a = 1'b1;
    ea = cyc;
    wait_sig("wait_sample_a", 0, 1'b1, 1100, s);
    chk("tick_to_sample_a", s - ea, 1000);
    wr = 0;
    lat = 0;
    for (int i = 0; i < 800 && !cnn_start_a; i++) begin
      if (i < 625) chk("raddr_a", fb_raddr_a, addr_of(i));
      if (i == 26)  chk("raddr_idx26", fb_raddr_a, 2892);
      if (i == 624) chk("raddr_idx624", fb_raddr_a, 69408);
      if (smp_we_a) begin
        chk("smp_idx_a", smp_idx_a, wr);
        chk("smp_data_a", smp_data_a, addr_of(wr) & 12'hfff);
        chk("wr_latency_a", i, wr + 2);
        wr++;
      end
      step();
      lat = i + 1;
    end
    chk("cnn_start_seen_a", cnn_start_a, 1);
    chk("cnn_start_lat_a", lat, 627);
    chk("n_writes_a", wr, 625);

    // ---- Instance A: happy path, class 5 finishes 100 cycles after start ----
    repeat (100) step();
    cnn_finish_a = 1'b1;
    cnn_class_a  = 4'd5;
    step();
    chk("msg_request_a", msg_request_a, 1);
    chk("msg_in_class5", msg_in_a, 8'b0010_0000);
    msg_done_a = 1'b1;
    step();
    msg_done_a = 1'b0;
    chk("msg_request_1cyc", msg_request_a, 0);
    chk("done_with_req_ignored", {busy_a, frame_cnt_a}, {1'b1, 8'd0});
    repeat (3) step();
    msg_done_a = 1'b1;
    step();
    msg_done_a = 1'b0;
    chk("frame_cnt_happy", frame_cnt_a, 1);
    chk("busy_after_done", busy_a, 0);
    chk("starts_a_once", nst_a, 1);
    chk("requests_a_once", nrq_a, 1);
    chk("writes_total_a", nwe_a, 625);

    // ---- Instance A: bad class, stale finish level present during START ----
    wait_sig("wait_sample2_a", 0, 1'b1, 400, s);
    chk("period_tick_a", s - ea, 2000);
    wait_sig("wait_start2_a", 2, 1'b1, 800, c);
    step();
    cnn_finish_a = 1'b0;
    chk("stale_finish_ignored", {msg_request_a, busy_a}, {1'b0, 1'b1});
    repeat (10) step();
    cnn_finish_a = 1'b1;
    cnn_class_a  = 4'd9;
    step();
    cnn_finish_a = 1'b0;
    chk("err_class_a", err_class_a, 1);
    chk("frame_cnt_badclass", frame_cnt_a, 2);
    chk("busy_badclass", busy_a, 0);
    repeat (3) step();
    chk("no_request_badclass", nrq_a, 1);
    chk("msg_in_held_a", msg_in_a, 8'b0010_0000);
    chk("flags_a", {err_timeout_a, err_overrun_a}, 2'b00);
    enable_a = 1'b0;

    // ---- Instance B: timeout ----
    enable_b = 1'b1;
    eb = cyc;
    wait_sig("wait_sample_b", 1, 1'b1, 800, s);
    chk("tick_to_sample_b", s - eb, 700);
    wait_sig("wait_start_b", 3, 1'b1, 800, c);
    chk("cnn_start_lat_b", c - s, 628);
    wait_sig("wait_timeout_b", 1, 1'b0, 100, at);
    chk("timeout_latency_b", at - c, 51);
    chk("err_timeout_b", err_timeout_b, 1);
    chk("frame_cnt_timeout", frame_cnt_b, 0);
    chk("no_request_timeout", nrq_b, 0);
    chk("writes_b", nwe_b, 625);

    // ---- Instance B: restart, then overrun while the messenger stalls ----
    wait_sig("wait_sample2_b", 1, 1'b1, 800, s);
    chk("restart_after_timeout", s - eb, 1400);
    wait_sig("wait_start2_b", 3, 1'b1, 800, c);
    step();
    cnn_finish_b = 1'b1;
    cnn_class_b  = 4'd2;
    step();
    chk("msg_request_b", msg_request_b, 1);
    chk("msg_in_class2", msg_in_b, 8'b0000_0100);
    chk("no_overrun_yet", err_overrun_b, 0);
    we0 = nwe_b;
    st0 = nst_b;
    repeat (1000) step();
    chk("err_overrun_b", err_overrun_b, 1);
    chk("busy_while_stalled", busy_b, 1);
    chk("no_new_sample", nwe_b - we0, 0);
    chk("no_new_start", nst_b - st0, 0);
    msg_done_b = 1'b1;
    step();
    msg_done_b = 1'b0;
    chk("frame_cnt_overrun", frame_cnt_b, 1);
    chk("idle_after_ack_b", busy_b, 0);
    wait_sig("wait_sample3_b", 1, 1'b1, 800, s);
    chk("next_sample_after_idle", s - eb, 3500);

    // ---- Instance B: reset at sample index 300 ----
    repeat (300) step();
    chk("raddr_idx300_b", fb_raddr_b, 34560);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rel = cyc;
    chk("midseq_reset_outputs", {fb_raddr_b, smp_we_b, smp_idx_b, smp_data_b, cnn_start_b, msg_in_b,
        msg_request_b, busy_b, err_overrun_b, err_timeout_b, err_class_b, frame_cnt_b}, 64'd0);
    we0 = nwe_b;
    repeat (10) step();
    chk("no_stray_we", nwe_b - we0, 0);
    wait_sig("wait_sample_after_rst", 1, 1'b1, 800, s);
    chk("tick_restart_after_rst", s - rel, 700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
